// File: rtl/mdu_unit.sv
// -----------------------------------------------------------------------------
// mdu_unit -- multiply/divide unit owning the architectural HI/LO registers.
//
// Multiply-class ops (mult, multu and, when enabled, madd/maddu/msub/msubu)
// keep Busy_E high for 5 cycles; divide-class ops (div, divu) keep it high
// for 10 cycles. Both counts include the Start_E cycle. mthi/mtlo write HI/LO
// on the Start_E edge and never stall. Operands and the op are captured at
// start, so input changes while busy have no effect. The result is written
// to HI/LO on the edge where the down-counter reaches zero.
//
// Optional feature: define MDU_MADD_EN to enable the multiply-accumulate ops
// 7..10. Without it those opcodes are no-ops and never raise Busy_E.
//
// Ports:
//   clk       in   1  system clock, rising edge
//   reset     in   1  synchronous active-high reset
//   Start_E   in   1  MDU_Op_E is a new E-stage MDU instruction this cycle
//   MDU_Op_E  in   4  operation code
//   SrcA_E    in  32  rs operand
//   SrcB_E    in  32  rt operand
//   Busy_E    out  1  stall request to the hazard unit
//   HI        out 32  architectural HI register
//   LO        out 32  architectural LO register
// -----------------------------------------------------------------------------
module mdu_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start_E,
  input  logic [3:0]  MDU_Op_E,
  input  logic [31:0] SrcA_E,
  input  logic [31:0] SrcB_E,
  output logic        Busy_E,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

`ifdef MDU_MADD_EN
  localparam logic MADD_EN = 1'b1;
`else
  localparam logic MADD_EN = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [3:0]  op_q,    op_d;
  logic [31:0] a_q,     a_d;
  logic [31:0] b_q,     b_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;

  // ---------------------------------------------------------------------------
  // Opcode decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic is_mul_op;
  logic is_div_op;

  always_comb begin
    is_mul_op = 1'b0;
    is_div_op = 1'b0;
    case (MDU_Op_E)
      OP_MULT, OP_MULTU:                     is_mul_op = 1'b1;
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU:  is_mul_op = MADD_EN;
      OP_DIV, OP_DIVU:                       is_div_op = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath on the captured operands
  // ---------------------------------------------------------------------------
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] a_s;
  logic signed [31:0] b_safe_s;
  logic        [31:0] b_safe;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;
  logic        [63:0] acc;
  logic        [63:0] result;

  always_comb begin
    prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u   = {32'd0, a_q} * {32'd0, b_q};
    // A zero divisor is replaced by 1 so the dividers never see x/0;
    // the result is discarded in that case anyway.
    b_safe   = (b_q == 32'd0) ? 32'd1 : b_q;
    a_s      = $signed(a_q);
    b_safe_s = $signed(b_safe);
    quo_s    = a_s / b_safe_s;
    rem_s    = a_s % b_safe_s;
    quo_u    = a_q / b_safe;
    rem_u    = a_q % b_safe;
    acc      = {hi_q, lo_q};

    result = acc;
    case (op_q)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   if (b_q != 32'd0) result = {rem_s, quo_s};
      OP_DIVU:  if (b_q != 32'd0) result = {rem_u, quo_u};
      OP_MADD:  result = acc + prod_s;
      OP_MADDU: result = acc + prod_u;
      OP_MSUB:  result = acc - prod_s;
      OP_MSUBU: result = acc - prod_u;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (Start_E) begin
          if (is_mul_op || is_div_op) begin
            op_d    = MDU_Op_E;
            a_d     = SrcA_E;
            b_d     = SrcB_E;
            cnt_d   = is_div_op ? 4'd9 : 4'd4;
            state_d = BUSY;
          end else if (MDU_Op_E == OP_MTHI) begin
            hi_d = SrcA_E;
          end else if (MDU_Op_E == OP_MTLO) begin
            lo_d = SrcA_E;
          end
        end
      end
      BUSY: begin
        // Start_E is ignored here. The edge on which cnt steps from 1 to 0
        // commits the result, giving 4 (mul) / 9 (div) BUSY cycles after
        // the Start_E cycle.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d        = 4'd0;
          {hi_d, lo_d} = result;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    Busy_E = (Start_E & (is_mul_op | is_div_op)) | (state_q == BUSY);
    HI     = hi_q;
    LO     = lo_q;
  end

endmodule
